// File: rtl/spi_rx_ctrl.sv
// SPI receive controller: synchronizes CS/SCLK/SDI, assembles MSB-first bytes
// and queues them in a first-word-fall-through FIFO with overflow/abort flags.
// Ports: CLK/RST (sync, active-high); CS/SCLK/SDI async serial inputs;
// RX_DATA/RX_VALID/RX_READY consumer handshake; RX_OVF sticky drop flag;
// FRAME_ERR one-cycle abort pulse; BUSY while receiving; FIFO_LEVEL occupancy.
module spi_rx_ctrl #(
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          CS,
  input  logic                          SCLK,
  input  logic                          SDI,
  output logic [7:0]                    RX_DATA,
  output logic                          RX_VALID,
  input  logic                          RX_READY,
  output logic                          RX_OVF,
  output logic                          FRAME_ERR,
  output logic                          BUSY,
  output logic [$clog2(FIFO_DEPTH):0]   FIFO_LEVEL
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    ABORT
  } state_t;

  logic [SYNC_STAGES-1:0] cs_sync_q;
  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] sdi_sync_q;
  logic                   cs_prev_q;
  logic                   sclk_prev_q;

  logic cs_s, sclk_s, sdi_s;
  logic sclk_rise, cs_fall, cs_rise;

  state_t      state_q, state_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        push_w;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] level_q, level_d;
  logic          ovf_q;
  logic          pop_w, full_w, wr_en_w;

  assign cs_s   = cs_sync_q[SYNC_STAGES-1];
  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign sdi_s  = sdi_sync_q[SYNC_STAGES-1];

  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign cs_fall   = ~cs_s & cs_prev_q;
  assign cs_rise   = cs_s & ~cs_prev_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      cs_sync_q   <= '1;
      sclk_sync_q <= '1;
      sdi_sync_q  <= '1;
      cs_prev_q   <= 1'b1;
      sclk_prev_q <= 1'b1;
    end else begin
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], CS};
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], SCLK};
      sdi_sync_q  <= {sdi_sync_q[SYNC_STAGES-2:0], SDI};
      cs_prev_q   <= cs_s;
      sclk_prev_q <= sclk_s;
    end
  end

  // A count of 8 means a finished byte waiting one cycle to be pushed; the
  // count drops back to 0 in the push cycle so the next byte has no gap.
  assign push_w = (bit_cnt_q == 4'd8);

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = push_w ? 4'd0 : bit_cnt_q;
    shift_d   = shift_q;
    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d   = RECV;
          bit_cnt_d = 4'd0;
          shift_d   = 8'h00;
        end
      end
      RECV: begin
        if (sclk_rise) begin
          bit_cnt_d = (push_w ? 4'd0 : bit_cnt_q) + 4'd1;
          shift_d   = {shift_q[6:0], sdi_s};
        end
        // CS rise is judged on the count after this cycle's SCLK rise;
        // a just-completed byte still gets pushed from IDLE.
        if (cs_rise) begin
          if (bit_cnt_d == 4'd0 || bit_cnt_d == 4'd8) begin
            state_d = IDLE;
          end else begin
            state_d = ABORT;
          end
        end
      end
      ABORT: begin
        state_d   = IDLE;
        bit_cnt_d = 4'd0;
        shift_d   = 8'h00;
      end
      default: begin
        state_d   = IDLE;
        bit_cnt_d = 4'd0;
        shift_d   = 8'h00;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      bit_cnt_q <= 4'd0;
      shift_q   <= 8'h00;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
    end
  end

  // A pop in the same cycle frees a slot, so a full FIFO still accepts.
  assign pop_w   = (level_q != '0) & RX_READY;
  assign full_w  = (level_q == LW'(FIFO_DEPTH));
  assign wr_en_w = push_w & (~full_w | pop_w);

  always_comb begin
    level_d = level_q;
    if (wr_en_w && !pop_w) begin
      level_d = level_q + LW'(1);
    end else if (!wr_en_w && pop_w) begin
      level_d = level_q - LW'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST && wr_en_w) begin
      mem_q[wr_ptr_q] <= shift_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      level_q <= level_d;
      if (wr_en_w) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop_w) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      if (push_w && full_w && !pop_w) begin
        ovf_q <= 1'b1;
      end
    end
  end

  assign RX_VALID   = (level_q != '0);
  assign RX_DATA    = RX_VALID ? mem_q[rd_ptr_q] : 8'h00;
  assign RX_OVF     = ovf_q;
  assign FRAME_ERR  = (state_q == ABORT);
  assign BUSY       = (state_q == RECV);
  assign FIFO_LEVEL = level_q;

endmodule

// File: doc/spi_rx_ctrl.md
SPI_RX_CTRL -- requirements
Module: spi_rx_ctrl

Interface
REQ-001 The module SHALL have these parameters (name, default, meaning):
- FIFO_DEPTH, 4, receive FIFO entries; power of two, 2..16.
- SYNC_STAGES, 2, synchronizer flops on CS, SCLK and SDI; at least 2.

REQ-002 The module SHALL have these ports (name, direction, width, meaning):
- CLK, in, 1, system clock.
- RST, in, 1, synchronous active-high reset.
- CS, in, 1, chip select, active low, asynchronous to CLK.
- SCLK, in, 1, serial clock, idles high, asynchronous to CLK.
- SDI, in, 1, serial data in; changes on SCLK falling edge, MSB first.
- RX_DATA, out, 8, head-of-FIFO byte; valid while RX_VALID=1.
- RX_VALID, out, 1, FIFO not empty.
- RX_READY, in, 1, consumer accepts RX_DATA when RX_VALID=1 and RX_READY=1.
- RX_OVF, out, 1, sticky flag: a byte was dropped because the FIFO was full.
- FRAME_ERR, out, 1, one-cycle pulse: CS deasserted mid-byte.
- BUSY, out, 1, high while the state is RECV.
- FIFO_LEVEL, out, clog2(FIFO_DEPTH)+1, current FIFO occupancy.

REQ-003 Reset RST SHALL be synchronous and active-high; clock CLK. All state SHALL update only on the CLK rising edge.

Function
REQ-004 CS, SCLK and SDI SHALL each pass through SYNC_STAGES flops. The synchronizer reset values SHALL be CS=1, SCLK=1, SDI=1.

REQ-005 Edge detection:
- A rising SCLK edge (rise) is synced SCLK = 1 with its previous synced value = 0.
- A CS fall or CS rise is detected the same way on synced CS.

REQ-006 The state machine SHALL have three states: IDLE, RECV, ABORT.
- IDLE -> RECV on CS fall.
- RECV -> IDLE on CS rise with bit_cnt = 0.
- RECV -> ABORT on CS rise with bit_cnt in 1..7.
- ABORT -> IDLE after exactly one cycle.

REQ-007 On entry to RECV, bit_cnt and the shift register SHALL be cleared to 0.

REQ-008 On each rise in RECV, the shift register SHALL shift left with synced SDI entering bit 0, and bit_cnt SHALL increment.

REQ-009 When a rise makes bit_cnt reach 8:
- the assembled byte SHALL be pushed on the next cycle;
- bit_cnt SHALL return to 0 in that same push cycle;
- consecutive bytes under continuous CS low SHALL therefore be received with no gap.

REQ-010 SCLK edges while in IDLE or ABORT SHALL be ignored.

REQ-011 In ABORT:
- FRAME_ERR SHALL be 1 for exactly that cycle;
- the partial byte SHALL be discarded;
- the FIFO SHALL be unchanged.

REQ-012 If a rise and a CS rise are detected in the same cycle, the rise SHALL be processed first, and the CS rise SHALL then be evaluated against the updated bit_cnt.

REQ-013 FIFO behaviour:
- First-word-fall-through: RX_DATA SHALL show the head entry combinationally from storage.
- RX_VALID SHALL equal (FIFO_LEVEL != 0).
- Read and write pointers SHALL wrap modulo FIFO_DEPTH.

REQ-014 A pop SHALL occur when RX_VALID=1 and RX_READY=1. RX_READY with an empty FIFO SHALL have no effect.

REQ-015 Push/pop interaction:
- Push and pop in the same cycle SHALL both take effect; FIFO_LEVEL is unchanged.
- This SHALL hold even when the FIFO is full, with no overflow.

REQ-016 A push to a full FIFO with no simultaneous pop SHALL:
- drop the byte;
- leave the FIFO unchanged;
- set RX_OVF, which SHALL stay 1 until RST.

REQ-017 Latency: RX_VALID SHALL rise no more than SYNC_STAGES+3 CLK cycles after the external SCLK rising edge that carries bit 0 of the byte into an empty FIFO.

REQ-018 Timing requirement on the external interface: SCLK high and low phases SHALL each be at least SYNC_STAGES+2 CLK periods. CS setup before the first SCLK fall, and hold after the last SCLK rise, SHALL each be at least SYNC_STAGES+2 CLK periods.

Reset
REQ-019 While RST=1, the following SHALL be cleared, overriding every other event in that cycle:
- state = IDLE;
- bit_cnt = 0; shift register = 0;
- FIFO pointers = 0; FIFO_LEVEL = 0;
- RX_VALID = 0; RX_OVF = 0; FRAME_ERR = 0; BUSY = 0; RX_DATA = 0.

REQ-020 RST asserted mid-byte SHALL discard the partial byte and SHALL NOT pulse FRAME_ERR. After release, reception SHALL begin only on a new CS fall.

REQ-021 FIFO storage contents need not be reset. RX_DATA SHALL read 0 while FIFO_LEVEL = 0 after reset.

Verification
REQ-022 Single byte, SCLK period 32 CLK, CS low, send 0xA5 then raise CS -> RX_DATA=0xA5, RX_VALID=1 within REQ-017 bound, FRAME_ERR never 1.

REQ-023 Back-to-back 0x01, 0x80, 0xFF, 0x3C under one CS low, RX_READY=0 -> FIFO_LEVEL=4; pops return the bytes in that order.

REQ-024 FIFO full, then a fifth byte 0x55 with RX_READY=0 -> 0x55 dropped, RX_OVF=1 and sticky, FIFO_LEVEL=4; RX_READY=1 held throughout a sixth byte -> no drop.

REQ-025 CS raised after 5 bits -> one-cycle FRAME_ERR, FIFO_LEVEL unchanged; next full byte 0xC3 received correctly.

REQ-026 RST pulsed after 4 bits of 0x99 with 2 bytes queued -> FIFO_LEVEL=0, RX_OVF=0, no FRAME_ERR; a following CS-low byte 0x42 is received as 0x42.

REQ-027 Simultaneous push and pop with FIFO full, RX_READY=1 -> FIFO_LEVEL stays 4, RX_OVF stays 0, order preserved.
